// File: rtl/farm_dram_bridge_pkg.sv
// -----------------------------------------------------------------------------
// farm_dram_bridge_pkg
// Shared types and constants for the farm-to-DRAM AXI4-Lite bridge:
//   - bridge_state_t : 3-bit bridge FSM state encoding
//   - BRIDGE_BASE_ADDR : DRAM byte address of farm record 0
//   - byte_swap()    : byte-order reversal used when DRAM_BYTE_SWAP_EN is set
// -----------------------------------------------------------------------------
package farm_dram_bridge_pkg;

    localparam int unsigned BRIDGE_ADDR_W    = 17;
    localparam int unsigned BRIDGE_DATA_W    = 32;
    localparam logic [BRIDGE_ADDR_W-1:0] BRIDGE_BASE_ADDR = 17'h10000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } bridge_state_t;

    // {b3,b2,b1,b0} -> {b0,b1,b2,b3}
    function automatic logic [BRIDGE_DATA_W-1:0] byte_swap(input logic [BRIDGE_DATA_W-1:0] d);
        logic [BRIDGE_DATA_W-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < BRIDGE_DATA_W / 8; i++) begin
            s[8*i +: 8] = d[BRIDGE_DATA_W - 8 - 8*i +: 8];
        end
        return s;
    endfunction

endpackage

// File: rtl/farm_dram_bridge_fsm.sv
// -----------------------------------------------------------------------------
// farm_dram_bridge_fsm
// State register and sequencing for the farm-to-DRAM bridge. One request at a
// time: IDLE -> AR -> R -> DONE for reads, IDLE -> AW -> W -> B -> DONE for
// writes. All handshake outputs are registered alongside the state.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid, req_rd   : farm request strobe and read(1)/write(0) select
//   ar_ready, r_valid,
//   aw_ready, w_ready,
//   b_valid             : AXI4-Lite handshake inputs from the DRAM
//   state               : current state (datapath uses it to latch/capture)
//   ar_valid, r_ready,
//   aw_valid, w_valid,
//   b_ready             : registered AXI4-Lite handshake outputs
//   out_valid           : one-cycle completion pulse to the farm
// -----------------------------------------------------------------------------
module farm_dram_bridge_fsm
    import farm_dram_bridge_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic          req_rd,
    input  logic          ar_ready,
    input  logic          r_valid,
    input  logic          aw_ready,
    input  logic          w_ready,
    input  logic          b_valid,
    output bridge_state_t state,
    output logic          ar_valid,
    output logic          r_ready,
    output logic          aw_valid,
    output logic          w_valid,
    output logic          b_ready,
    output logic          out_valid
);

    // Each VALID/READY is set on entry to its state and cleared on the
    // transition out, so it is high for exactly the cycles spent in that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ar_valid  <= 1'b0;
            r_ready   <= 1'b0;
            aw_valid  <= 1'b0;
            w_valid   <= 1'b0;
            b_ready   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_rd) begin
                            state    <= ST_AR;
                            ar_valid <= 1'b1;
                        end else begin
                            state    <= ST_AW;
                            aw_valid <= 1'b1;
                        end
                    end
                end
                ST_AR: begin
                    if (ar_ready) begin
                        state    <= ST_R;
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                    end
                end
                ST_R: begin
                    if (r_valid) begin
                        state     <= ST_DONE;
                        r_ready   <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                ST_AW: begin
                    if (aw_ready) begin
                        state    <= ST_W;
                        aw_valid <= 1'b0;
                        w_valid  <= 1'b1;
                    end
                end
                ST_W: begin
                    if (w_ready) begin
                        state   <= ST_B;
                        w_valid <= 1'b0;
                        b_ready <= 1'b1;
                    end
                end
                ST_B: begin
                    if (b_valid) begin
                        state     <= ST_DONE;
                        b_ready   <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    ar_valid <= 1'b0;
                    r_ready  <= 1'b0;
                    aw_valid <= 1'b0;
                    w_valid  <= 1'b0;
                    b_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/farm_dram_bridge.sv
// -----------------------------------------------------------------------------
// farm_dram_bridge
// Converts single-word farm cache requests into AXI4-Lite read or write
// transactions toward the DRAM model, returning read data or a write
// acknowledge as a one-cycle C_out_valid pulse. One request outstanding.
// Configuration macro: DRAM_BYTE_SWAP_EN -- when defined, W_DATA and C_data_r
// are byte-reversed relative to C_data_w and R_DATA; otherwise straight through.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   C_addr, C_data_w,
//   C_in_valid, C_r_wb         : farm request (record index, data, strobe, 1=read)
//   C_out_valid, C_data_r      : completion pulse and last read data
//   AR_*, R_*                  : AXI4-Lite read address / read data channels
//   AW_*, W_*, B_*             : AXI4-Lite write address / data / response
// -----------------------------------------------------------------------------
module farm_dram_bridge
    import farm_dram_bridge_pkg::*;
#(
    parameter int unsigned            ADDR_W    = BRIDGE_ADDR_W,
    parameter int unsigned            DATA_W    = BRIDGE_DATA_W,
    parameter logic [ADDR_W-1:0]      BASE_ADDR = BRIDGE_BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        C_addr,
    input  logic [DATA_W-1:0] C_data_w,
    input  logic              C_in_valid,
    input  logic              C_r_wb,
    output logic              C_out_valid,
    output logic [DATA_W-1:0] C_data_r,
    output logic              AR_VALID,
    output logic [ADDR_W-1:0] AR_ADDR,
    input  logic              AR_READY,
    input  logic              R_VALID,
    input  logic [DATA_W-1:0] R_DATA,
    input  logic [1:0]        R_RESP,
    output logic              R_READY,
    output logic              AW_VALID,
    output logic [ADDR_W-1:0] AW_ADDR,
    input  logic              AW_READY,
    output logic              W_VALID,
    output logic [DATA_W-1:0] W_DATA,
    input  logic              W_READY,
    input  logic              B_VALID,
    input  logic [1:0]        B_RESP,
    output logic              B_READY
);

    bridge_state_t     state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] wdata_in;
    logic [DATA_W-1:0] rdata_in;
    logic              unused_resp;

    // Responses carry no error path.
    assign unused_resp = ^{R_RESP, B_RESP};

    assign req_addr = BASE_ADDR + ADDR_W'({C_addr, 2'b00});

`ifdef DRAM_BYTE_SWAP_EN
    assign wdata_in = byte_swap(C_data_w);
    assign rdata_in = byte_swap(R_DATA);
`else
    assign wdata_in = C_data_w;
    assign rdata_in = R_DATA;
`endif

    farm_dram_bridge_fsm u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (C_in_valid),
        .req_rd    (C_r_wb),
        .ar_ready  (AR_READY),
        .r_valid   (R_VALID),
        .aw_ready  (AW_READY),
        .w_ready   (W_READY),
        .b_valid   (B_VALID),
        .state     (state),
        .ar_valid  (AR_VALID),
        .r_ready   (R_READY),
        .aw_valid  (AW_VALID),
        .w_valid   (W_VALID),
        .b_ready   (B_READY),
        .out_valid (C_out_valid)
    );

    // Swap is applied on the way into the registers so W_DATA/C_data_r stay
    // pure flop outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            C_data_r <= '0;
        end else begin
            if (state == ST_IDLE && C_in_valid) begin
                addr_q  <= req_addr;
                wdata_q <= wdata_in;
            end
            if (state == ST_R && R_VALID) begin
                C_data_r <= rdata_in;
            end
        end
    end

    assign AR_ADDR = addr_q;
    assign AW_ADDR = addr_q;
    assign W_DATA  = wdata_q;

endmodule

// File: tb/tb_farm_dram_bridge.sv
module tb_farm_dram_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  C_addr = '0;
    logic [31:0] C_data_w = '0;
    logic        C_in_valid = 1'b0;
    logic        C_r_wb = 1'b0;
    logic        C_out_valid;
    logic [31:0] C_data_r;
    logic        AR_VALID;
    logic [16:0] AR_ADDR;
    logic        AR_READY = 1'b0;
    logic        R_VALID = 1'b0;
    logic [31:0] R_DATA = '0;
    logic [1:0]  R_RESP = '0;
    logic        R_READY;
    logic        AW_VALID;
    logic [16:0] AW_ADDR;
    logic        AW_READY = 1'b0;
    logic        W_VALID;
    logic [31:0] W_DATA;
    logic        W_READY = 1'b0;
    logic        B_VALID = 1'b0;
    logic [1:0]  B_RESP = '0;
    logic        B_READY;

    int errors = 0;
    int checks = 0;
    int ar_hs = 0;
    int ov_cnt = 0;
    bit overlap_seen = 1'b0;
    logic [31:0] exp_cdr = '0;
    logic [31:0] mem [int];

    farm_dram_bridge dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .C_addr     (C_addr),
        .C_data_w   (C_data_w),
        .C_in_valid (C_in_valid),
        .C_r_wb     (C_r_wb),
        .C_out_valid(C_out_valid),
        .C_data_r   (C_data_r),
        .AR_VALID   (AR_VALID),
        .AR_ADDR    (AR_ADDR),
        .AR_READY   (AR_READY),
        .R_VALID    (R_VALID),
        .R_DATA     (R_DATA),
        .R_RESP     (R_RESP),
        .R_READY    (R_READY),
        .AW_VALID   (AW_VALID),
        .AW_ADDR    (AW_ADDR),
        .AW_READY   (AW_READY),
        .W_VALID    (W_VALID),
        .W_DATA     (W_DATA),
        .W_READY    (W_READY),
        .B_VALID    (B_VALID),
        .B_RESP     (B_RESP),
        .B_READY    (B_READY)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (AR_VALID && AR_READY) ar_hs++;
        if (C_out_valid) ov_cnt++;
    end

    always @(negedge clk) begin
        if (AW_VALID && W_VALID) overlap_seen = 1'b1;
    end

    // Expected DRAM-side image of a farm word (and vice versa).
    function automatic logic [31:0] model_swap(input logic [31:0] d);
        logic [31:0] r;
`ifdef DRAM_BYTE_SWAP_EN
        r = {<<8{d}};
`else
        r = d;
`endif
        return r;
    endfunction

    function automatic logic [16:0] rec_addr(input logic [7:0] idx);
        int a;
        a = 'h10000 + 4 * int'(idx);
        return a[16:0];
    endfunction

    function automatic logic [31:0] mem_rd(input logic [16:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({C_out_valid, C_data_r, AR_VALID, AR_ADDR, R_READY,
                     AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY});
    endfunction

    task automatic do_read(input logic [7:0] idx, input int ar_dly, input int r_dly,
                           input logic [31:0] exp, input bit repulse);
        int ar0, ov0;
        bit stable;
        logic [16:0] a0;
        ar0 = ar_hs;
        ov0 = ov_cnt;
        @(negedge clk);
        C_addr = idx; C_r_wb = 1'b1; C_in_valid = 1'b1; C_data_w = $urandom;
        @(negedge clk);
        C_in_valid = 1'b0;
        chk("rd_ar_valid", {AR_VALID, AW_VALID}, 2'b10);
        chk("rd_ar_addr", AR_ADDR, rec_addr(idx));
        a0 = AR_ADDR;
        stable = 1'b1;
        repeat (ar_dly) begin
            @(negedge clk);
            if (AR_VALID !== 1'b1 || AR_ADDR !== a0 || C_out_valid !== 1'b0) stable = 1'b0;
        end
        chk("rd_ar_stable", stable, 1'b1);
        AR_READY = 1'b1;
        @(negedge clk);
        AR_READY = 1'b0;
        chk("rd_ar_drop", {AR_VALID, R_READY}, 2'b01);
        if (repulse) begin
            C_in_valid = 1'b1; C_r_wb = 1'b1; C_addr = idx + 8'd1;
        end
        stable = 1'b1;
        repeat (r_dly) begin
            @(negedge clk);
            C_in_valid = 1'b0;
            if (R_READY !== 1'b1 || C_out_valid !== 1'b0 || AR_VALID !== 1'b0) stable = 1'b0;
        end
        chk("rd_r_wait", stable, 1'b1);
        R_VALID = 1'b1;
        R_DATA = mem_rd(a0);
        @(negedge clk);
        R_VALID = 1'b0;
        C_in_valid = 1'b0;
        R_DATA = $urandom;
        chk("rd_out_valid", {C_out_valid, R_READY}, 2'b10);
        chk("rd_data", C_data_r, exp);
        exp_cdr = exp;
        @(negedge clk);
        chk("rd_pulse_end", C_out_valid, 1'b0);
        repeat (4) @(negedge clk);
        chk("rd_idle", {AR_VALID, AW_VALID, C_out_valid}, 3'b000);
        chk("rd_ar_count", ar_hs - ar0, 1);
        chk("rd_ov_count", ov_cnt - ov0, 1);
    endtask

    task automatic do_write(input logic [7:0] idx, input logic [31:0] data,
                            input int aw_dly, input int w_dly, input int b_dly);
        int ov0;
        bit stable;
        logic [16:0] a0;
        logic [31:0] d0;
        ov0 = ov_cnt;
        @(negedge clk);
        C_addr = idx; C_r_wb = 1'b0; C_in_valid = 1'b1; C_data_w = data;
        @(negedge clk);
        C_in_valid = 1'b0;
        C_data_w = $urandom;
        chk("wr_aw_valid", {AW_VALID, W_VALID, AR_VALID}, 3'b100);
        chk("wr_aw_addr", AW_ADDR, rec_addr(idx));
        a0 = AW_ADDR;
        stable = 1'b1;
        repeat (aw_dly) begin
            @(negedge clk);
            if (AW_VALID !== 1'b1 || W_VALID !== 1'b0 || AW_ADDR !== a0) stable = 1'b0;
        end
        chk("wr_aw_stable", stable, 1'b1);
        AW_READY = 1'b1;
        @(negedge clk);
        AW_READY = 1'b0;
        chk("wr_w_valid", {AW_VALID, W_VALID}, 2'b01);
        chk("wr_w_data", W_DATA, model_swap(data));
        d0 = W_DATA;
        stable = 1'b1;
        repeat (w_dly) begin
            @(negedge clk);
            if (W_VALID !== 1'b1 || W_DATA !== d0 || B_READY !== 1'b0) stable = 1'b0;
        end
        chk("wr_w_stable", stable, 1'b1);
        W_READY = 1'b1;
        mem[int'(a0)] = W_DATA;
        @(negedge clk);
        W_READY = 1'b0;
        chk("wr_b_ready", {W_VALID, B_READY}, 2'b01);
        stable = 1'b1;
        repeat (b_dly) begin
            @(negedge clk);
            if (B_READY !== 1'b1 || C_out_valid !== 1'b0) stable = 1'b0;
        end
        chk("wr_b_wait", stable, 1'b1);
        B_VALID = 1'b1;
        @(negedge clk);
        B_VALID = 1'b0;
        chk("wr_out_valid", {C_out_valid, B_READY}, 2'b10);
        chk("wr_cdr_kept", C_data_r, exp_cdr);
        @(negedge clk);
        chk("wr_pulse_end", C_out_valid, 1'b0);
        chk("wr_ov_count", ov_cnt - ov0, 1);
    endtask

    initial begin
        logic [7:0]  idx;
        logic [31:0] data;

        // Reset state
        #1;
        chk("reset_outputs", all_outs(), 128'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_outputs", all_outs(), 128'h0);

        // Directed read of record 5 with zero and five cycles of DRAM delay
        mem['h10014] = 32'hDEADBEEF;
        do_read(8'h05, 0, 0, model_swap(32'hDEADBEEF), 1'b0);
        do_read(8'h05, 5, 5, model_swap(32'hDEADBEEF), 1'b0);

        // Directed write to the last record
        do_write(8'hFF, 32'h12345678, 0, 0, 0);
        chk("wr_mem_103fc", mem_rd(17'h103FC), model_swap(32'h12345678));

        // Random write-then-read pairs
        for (int i = 0; i < 8; i++) begin
            idx  = 8'($urandom_range(0, 255));
            data = $urandom;
            do_write(idx, data, $urandom_range(0, 10), $urandom_range(0, 10), $urandom_range(0, 10));
            do_read(idx, $urandom_range(0, 10), $urandom_range(0, 10), data, 1'b0);
        end

        // Request re-pulsed while waiting for read data
        do_read(8'h05, 1, 3, model_swap(32'hDEADBEEF), 1'b1);

        // Reset in the middle of a write data phase
        @(negedge clk);
        C_addr = 8'h03; C_r_wb = 1'b0; C_in_valid = 1'b1; C_data_w = 32'hCAFEF00D;
        @(negedge clk);
        C_in_valid = 1'b0;
        AW_READY = 1'b1;
        @(negedge clk);
        AW_READY = 1'b0;
        chk("rst_in_w", W_VALID, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_outputs", all_outs(), 128'h0);
        exp_cdr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_idle", all_outs(), 128'h0);
        do_read(8'h05, 2, 1, model_swap(32'hDEADBEEF), 1'b0);

        // Address stalled for 100 cycles
        do_read(8'hFF, 100, 0, 32'h12345678, 1'b0);

        chk("no_aw_w_overlap", overlap_seen, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
